// File: rtl/neuron_input_packer.sv
// neuron_input_packer
// Packs a serial valid/ready stream of activation beats into the flat vector
// consumed by the neuron's data_input port. Two banks ping-pong: one fills
// while the other is held stable for the consumer, so a one-beat-per-cycle
// stream flows without stalls as long as the consumer keeps up.
module neuron_input_packer #(
  parameter int Input_Data_Width = 8,
  parameter int Number_of_Inputs = 192
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         in_valid,
  output logic                                         in_ready,
  input  logic [Input_Data_Width-1:0]                  in_data,
  input  logic                                         in_last,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic [Input_Data_Width*Number_of_Inputs-1:0] data_output,
  output logic                                         len_err
);

  localparam int W     = Input_Data_Width;
  localparam int N     = Number_of_Inputs;
  localparam int VEC_W = W * N;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  // Storage and control state
  logic [VEC_W-1:0] bank_q [2];
  logic [1:0]       full_q,    full_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0] wr_idx_q,  wr_idx_d;
  logic             len_err_q, len_err_d;

  logic accept;
  logic at_end;
  logic close_vec;
  logic drain;

  // Ready/valid come straight from registered state, so there is no
  // combinational path from the input side to the output side.
  assign in_ready    = !full_q[wr_bank_q];
  assign out_valid   = full_q[rd_bank_q];
  assign data_output = bank_q[rd_bank_q];
  assign len_err     = len_err_q;

  assign accept    = in_valid && in_ready;
  assign at_end    = (wr_idx_q == LAST_IDX);
  assign close_vec = accept && (at_end || in_last);
  assign drain     = out_valid && out_ready;

  // Next-state logic for bank flags, pointers and the length-error pulse.
  // A close and a drain in the same cycle always touch different banks:
  // closing needs the write bank empty, draining needs the read bank full.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_idx_d  = wr_idx_q;
    len_err_d = 1'b0;
    if (accept) begin
      if (close_vec) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = !wr_bank_q;
        wr_idx_d          = '0;
        // Clean close only when in_last lands exactly on the final slot.
        len_err_d         = (at_end != in_last);
      end else begin
        wr_idx_d = wr_idx_q + IDX_W'(1);
      end
    end
    if (drain) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = !rd_bank_q;
    end
  end

  // Control registers
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (rst) begin
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_idx_q  <= '0;
      len_err_q <= 1'b0;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_idx_q  <= wr_idx_d;
      len_err_q <= len_err_d;
    end
  end

  // Bank storage: write the accepted beat into its slot, zero a bank as it
  // is handed back so a later short vector reads zeros in unwritten slots.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the banks are deliberately reset; short vectors rely on
      // unwritten slots reading zero, and data_output must be 0 out of reset.
      bank_q[0] <= '0;
      bank_q[1] <= '0;
    end else begin
      if (accept) begin
        bank_q[wr_bank_q][W*int'(wr_idx_q) +: W] <= in_data;
      end
      if (drain) begin
        bank_q[rd_bank_q] <= '0;
      end
    end
  end

endmodule

// File: tb/tb_neuron_input_packer.sv
// Testbench for neuron_input_packer: randomized and directed stimulus, a
// vector-level reference model and a scoreboard drained by a monitor.
module tb_neuron_input_packer;

  localparam int W     = 8;
  localparam int N     = 192;
  localparam int VEC_W = W * N;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [VEC_W-1:0] data_output;
  logic             len_err;

  // out_ready is either driven by the sequence or randomized each cycle
  logic rdy_man  = 1'b0;
  logic rand_rdy = 1'b0;
  logic rnd_bit  = 1'b0;
  assign out_ready = rand_rdy ? rnd_bit : rdy_man;

  neuron_input_packer #(
    .Input_Data_Width(W),
    .Number_of_Inputs(N)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .data_output(data_output),
    .len_err    (len_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    rnd_bit = 1'($urandom_range(0, 1));
  end

  int n_cmp  = 0;
  int n_fail = 0;
  int stalls = 0;
  bit mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_vec(input string name, input logic [VEC_W-1:0] act, input logic [VEC_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      for (int k = 0; k < N; k++) begin
        if (act[k*W +: W] !== exp[k*W +: W]) begin
          $display("FAIL %s: slot %0d got %0h expected %0h at %0t",
                   name, k, act[k*W +: W], exp[k*W +: W], $time);
          break;
        end
      end
    end
  endtask

  // Reference model: beats collect into a list; a vector is complete when it
  // holds N beats or in_last arrives; at most two complete vectors are held.
  logic [VEC_W-1:0] exp_q [$];
  logic [W-1:0]     cur   [$];
  int held    = 0;
  bit exp_err = 1'b0;
  bit acc_flag = 1'b0;
  bit drn;
  logic [VEC_W-1:0] vec;

  always @(posedge clk) begin
    if (rst) begin
      held     = 0;
      cur.delete();
      exp_q.delete();
      exp_err  = 1'b0;
      acc_flag = 1'b0;
    end else begin
      acc_flag = in_valid && (held < 2);
      drn      = out_ready && (held > 0);
      exp_err  = 1'b0;
      if (acc_flag) begin
        cur.push_back(in_data);
        if (in_last || cur.size() == N) begin
          vec = '0;
          for (int k = 0; k < cur.size(); k++) vec[k*W +: W] = cur[k];
          exp_q.push_back(vec);
          exp_err = !(in_last && cur.size() == N);
          cur.delete();
          held++;
        end
      end
      if (drn) held--;
    end
  end

  // Monitor: compares handshake state every cycle and pops the scoreboard
  // whenever the DUT hands over a vector.
  always @(negedge clk) begin
    if (mon_en) begin
      check("out_valid", 32'(out_valid), 32'(held > 0));
      check("in_ready",  32'(in_ready),  32'(held < 2));
      check("len_err",   32'(len_err),   32'(exp_err));
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_vector: got a vector, expected none at %0t", $time);
        end else begin
          check_vec("data_output", data_output, exp_q.pop_front());
        end
      end
    end
  end

  task automatic send_beat(input logic [W-1:0] d, input logic l);
    int waits;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    waits    = 0;
    while (1) begin
      @(posedge clk);
      #1;
      if (acc_flag) break;
      waits++;
      stalls++;
      if (waits > 3000) begin
        n_cmp++;
        n_fail++;
        $display("FAIL beat_timeout: got no acceptance, expected one within 3000 cycles");
        break;
      end
    end
  endtask

  // mode 0: data = k, mode 1: constant c, mode 2: random
  task automatic send_vec(input int len, input int mode, input logic [W-1:0] c, input bit last_at_end);
    logic [W-1:0] d;
    for (int k = 0; k < len; k++) begin
      case (mode)
        0:       d = W'(k);
        1:       d = c;
        default: d = W'($urandom);
      endcase
      send_beat(d, last_at_end && (k == len - 1));
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (held != 0 || cur.size() != 0) begin
      @(posedge clk);
      #1;
      n++;
      if (n > 3000) begin
        n_cmp++;
        n_fail++;
        $display("FAIL drain_timeout: got %0d held, expected 0", held);
        break;
      end
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // 1. Reset with in_valid high: nothing accepted, outputs at reset values
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h55;
    in_last  = 1'b1;
    cycles(2);
    rst      = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    mon_en   = 1'b1;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset len_err", 32'(len_err), 32'd0);
    check_vec("reset data_output", data_output, '0);

    // 2. Single full vector with data = k, held until one ready pulse
    send_vec(N, 0, '0, 1'b1);
    cycles(3);
    rdy_man = 1'b1;
    cycles(1);
    rdy_man = 1'b0;
    cycles(2);

    // 3. Back-pressure: two vectors fill both banks, a third stalls until
    //    a single ready pulse frees one bank
    send_vec(N, 2, '0, 1'b1);
    send_vec(N, 1, 8'hA5, 1'b1);
    fork
      send_vec(N, 2, '0, 1'b1);
      begin
        cycles(10);
        rdy_man = 1'b1;
        cycles(1);
        rdy_man = 1'b0;
      end
    join
    cycles(4);
    rdy_man = 1'b1;
    wait_idle();

    // 4. Short vector: 10 beats of 7F, remaining slots read zero
    send_vec(10, 1, 8'h7F, 1'b1);
    wait_idle();

    // 5. Missing in_last: closes at N, next beats start the other bank
    send_vec(N, 2, '0, 1'b0);
    send_vec(5, 2, '0, 1'b1);
    wait_idle();
    cycles(2);

    // 6. Continuous streaming: four back-to-back vectors never stall
    stalls = 0;
    for (int v = 0; v < 4; v++) send_vec(N, 2, '0, 1'b1);
    check("stream stalls", 32'(stalls), 32'd0);
    wait_idle();

    // Mid-vector reset discards the partial vector
    send_vec(50, 2, '0, 1'b0);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    check("midreset out_valid", 32'(out_valid), 32'd0);
    check_vec("midreset data_output", data_output, '0);
    send_vec(N, 0, '0, 1'b1);
    wait_idle();

    // 7. Random lengths and termination with a random consumer
    rand_rdy = 1'b1;
    for (int v = 0; v < 8; v++) begin
      case ($urandom_range(0, 3))
        0:       send_vec(N, 2, '0, 1'b0);
        1:       send_vec(int'($urandom_range(1, N - 1)), 2, '0, 1'b1);
        default: send_vec(N, 2, '0, 1'b1);
      endcase
    end
    rand_rdy = 1'b0;
    rdy_man  = 1'b1;
    wait_idle();
    cycles(3);
    check("scoreboard empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
